// File: rtl/dose_countdown_timer.sv
// dose_countdown_timer: presets an HH:MM:SS BCD countdown from a ROM dose word,
// decrements it once per second and raises an alarm at 00:00:00 until acknowledged.
`default_nettype none

module dose_countdown_timer #(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_pulse,
   input  logic        start_pulse,
   input  logic        pause_pulse,
   input  logic        ack_pulse,
   input  logic [7:0]  rom_content,
   output logic [23:0] time_bcd,
   output logic [3:0]  med_id,
   output logic        alarm,
   output logic        running
);

   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] C_LAST_TICK = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOADED  = 3'd1,
      S_RUNNING = 3'd2,
      S_PAUSED  = 3'd3,
      S_ALARM   = 3'd4
   } state_t;

   state_t        state_q;
   logic [23:0]   time_q;
   logic [3:0]    med_q;
   logic [3:0]    hours_q;
   logic [PW-1:0] presc_q;
   logic          alarm_q;
   logic          running_q;

   // Binary hours (1..15) to two BCD digits.
   function automatic logic [7:0] hours_to_bcd(input logic [3:0] h);
      if (h >= 4'd10) begin
         hours_to_bcd = {4'd1, h - 4'd10};
      end else begin
         hours_to_bcd = {4'd0, h};
      end
   endfunction

   // One BCD digit step of the borrow chain: returns {borrow_out, new_digit}.
   function automatic logic [4:0] digit_dec(input logic [3:0] d, input logic [3:0] max,
                                            input logic bin);
      if (!bin) begin
         digit_dec = {1'b0, d};
      end else if (d == 4'd0) begin
         digit_dec = {1'b1, max};
      end else begin
         digit_dec = {1'b0, d - 4'd1};
      end
   endfunction

   logic [4:0]  s0_d, s1_d, m0_d, m1_d, h0_d, h1_d;
   logic [23:0] time_dec_d;
   logic        expire_d;
   logic        tick_d;
   logic        cmd_load, cmd_ack, cmd_pause, cmd_start;

   always_comb begin
      s0_d = digit_dec(time_q[3:0],   4'd9, 1'b1);
      s1_d = digit_dec(time_q[7:4],   4'd5, s0_d[4]);
      m0_d = digit_dec(time_q[11:8],  4'd9, s1_d[4]);
      m1_d = digit_dec(time_q[15:12], 4'd5, m0_d[4]);
      h0_d = digit_dec(time_q[19:16], 4'd9, m1_d[4]);
      h1_d = digit_dec(time_q[23:20], 4'd1, h0_d[4]);
      time_dec_d = {h1_d[3:0], h0_d[3:0], m1_d[3:0], m0_d[3:0], s1_d[3:0], s0_d[3:0]};
      // A zero start value also lands in ALARM rather than wrapping to 19:59:59.
      expire_d = (time_dec_d == 24'h0) || (time_q == 24'h0);
      tick_d   = (presc_q == C_LAST_TICK);
   end

   // An invalid load still claims the command slot, dropping coincident pulses.
   assign cmd_load  = load_pulse && (rom_content[3:0] != 4'd0);
   assign cmd_ack   = !load_pulse && ack_pulse;
   assign cmd_pause = !load_pulse && !ack_pulse && pause_pulse;
   assign cmd_start = !load_pulse && !ack_pulse && !pause_pulse && start_pulse;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         time_q    <= 24'h0;
         med_q     <= 4'd0;
         hours_q   <= 4'd0;
         presc_q   <= '0;
         alarm_q   <= 1'b0;
         running_q <= 1'b0;
      end else if (cmd_load) begin
         med_q     <= rom_content[7:4];
         hours_q   <= rom_content[3:0];
         time_q    <= {hours_to_bcd(rom_content[3:0]), 16'h0};
         presc_q   <= '0;
         state_q   <= S_LOADED;
         alarm_q   <= 1'b0;
         running_q <= 1'b0;
      end else begin
         case (state_q)
            S_LOADED, S_PAUSED: begin
               if (cmd_start) begin
                  presc_q   <= '0;
                  state_q   <= S_RUNNING;
                  running_q <= 1'b1;
               end
            end
            S_RUNNING: begin
               if (cmd_pause) begin
                  state_q   <= S_PAUSED;
                  running_q <= 1'b0;
               end else if (tick_d) begin
                  presc_q <= '0;
                  if (expire_d) begin
                     time_q    <= 24'h0;
                     state_q   <= S_ALARM;
                     running_q <= 1'b0;
                     alarm_q   <= 1'b1;
                  end else begin
                     time_q <= time_dec_d;
                  end
               end else begin
                  presc_q <= presc_q + PW'(1);
               end
            end
            S_ALARM: begin
               if (cmd_ack) begin
                  time_q    <= {hours_to_bcd(hours_q), 16'h0};
                  presc_q   <= '0;
                  state_q   <= S_RUNNING;
                  running_q <= 1'b1;
                  alarm_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= state_q;
            end
         endcase
      end
   end

   assign time_bcd = time_q;
   assign med_id   = med_q;
   assign alarm    = alarm_q;
   assign running  = running_q;

endmodule

`default_nettype wire

// File: tb/tb_dose_countdown_timer.sv
// tb_dose_countdown_timer: directed-vector bench for dose_countdown_timer at 4 clocks per second.
`default_nettype none

module tb_dose_countdown_timer;

   logic        clk;
   logic        reset;
   logic        load_pulse;
   logic        start_pulse;
   logic        pause_pulse;
   logic        ack_pulse;
   logic [7:0]  rom_content;
   logic [23:0] time_bcd;
   logic [3:0]  med_id;
   logic        alarm;
   logic        running;

   int checks;
   int errors;

   dose_countdown_timer #(.TICKS_PER_SEC(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .load_pulse  (load_pulse),
      .start_pulse (start_pulse),
      .pause_pulse (pause_pulse),
      .ack_pulse   (ack_pulse),
      .rom_content (rom_content),
      .time_bcd    (time_bcd),
      .med_id      (med_id),
      .alarm       (alarm),
      .running     (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Advance n edges, settling 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [23:0] t, input logic [3:0] id,
                            input logic al, input logic run);
      check({tag, ".time"},    {8'h0, time_bcd}, {8'h0, t});
      check({tag, ".med_id"},  {28'h0, med_id},  {28'h0, id});
      check({tag, ".alarm"},   {31'h0, alarm},   {31'h0, al});
      check({tag, ".running"}, {31'h0, running}, {31'h0, run});
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      load_pulse  = 1'b0;
      start_pulse = 1'b0;
      pause_pulse = 1'b0;
      ack_pulse   = 1'b0;
      rom_content = 8'h31;
      step(2);
      check_out("reset", 24'h0, 4'h0, 1'b0, 1'b0);
      reset = 1'b0;
      step(1);

      // 1: load 1 hour, medication 3
      load_pulse = 1'b1; step(1); load_pulse = 1'b0;
      check_out("load31", 24'h010000, 4'h3, 1'b0, 1'b0);

      // 2: full one-hour countdown to alarm
      start_pulse = 1'b1; step(1); start_pulse = 1'b0;
      step(3);
      check_out("run3clk", 24'h010000, 4'h3, 1'b0, 1'b1);
      step(1);
      check("tick1", {8'h0, time_bcd}, 32'h00005959);
      step(4);
      check("tick2", {8'h0, time_bcd}, 32'h00005958);
      step(14400 - 8 - 1);
      check_out("last_sec", 24'h000001, 4'h3, 1'b0, 1'b1);
      step(1);
      check_out("expire", 24'h000000, 4'h3, 1'b1, 1'b0);
      step(100);
      check_out("alarm_hold", 24'h000000, 4'h3, 1'b1, 1'b0);
      start_pulse = 1'b1; step(1); start_pulse = 1'b0;
      check_out("start_in_alarm", 24'h000000, 4'h3, 1'b1, 1'b0);

      // 4: ack re-arms; load beats pause and ack; invalid load ignored
      ack_pulse = 1'b1; step(1); ack_pulse = 1'b0;
      check_out("ack", 24'h010000, 4'h3, 1'b0, 1'b1);
      step(4);
      check("ack_tick", {8'h0, time_bcd}, 32'h00005959);
      rom_content = 8'h21;
      load_pulse = 1'b1; ack_pulse = 1'b1; pause_pulse = 1'b1; step(1);
      load_pulse = 1'b0; ack_pulse = 1'b0; pause_pulse = 1'b0;
      check_out("load_wins", 24'h010000, 4'h2, 1'b0, 1'b0);
      rom_content = 8'h70;
      load_pulse = 1'b1; step(1); load_pulse = 1'b0;
      check_out("load_zero_hours", 24'h010000, 4'h2, 1'b0, 1'b0);
      rom_content = 8'h95;
      step(3);
      check_out("rom_idle_change", 24'h010000, 4'h2, 1'b0, 1'b0);

      // 5: full borrow chain 10:00:00 -> 09:59:59
      rom_content = 8'h0A;
      load_pulse = 1'b1; step(1); load_pulse = 1'b0;
      check_out("load0A", 24'h100000, 4'h0, 1'b0, 1'b0);
      start_pulse = 1'b1; step(1); start_pulse = 1'b0;
      step(4);
      check_out("borrow_chain", 24'h095959, 4'h0, 1'b0, 1'b1);

      // 3: 12 hours, pause after 10 ticks, resume
      rom_content = 8'h5C;
      load_pulse = 1'b1; step(1); load_pulse = 1'b0;
      check_out("load5C", 24'h120000, 4'h5, 1'b0, 1'b0);
      start_pulse = 1'b1; step(1); start_pulse = 1'b0;
      step(40);
      check("ten_ticks", {8'h0, time_bcd}, 32'h00115950);
      pause_pulse = 1'b1; start_pulse = 1'b1; step(1);
      pause_pulse = 1'b0; start_pulse = 1'b0;
      check_out("paused", 24'h115950, 4'h5, 1'b0, 1'b0);
      step(40);
      check_out("pause_hold", 24'h115950, 4'h5, 1'b0, 1'b0);
      start_pulse = 1'b1; step(1); start_pulse = 1'b0;
      check("resume_run", {31'h0, running}, 32'h1);
      step(3);
      check("resume_3clk", {8'h0, time_bcd}, 32'h00115950);
      step(1);
      check("resume_4clk", {8'h0, time_bcd}, 32'h00115949);

      // 6: asynchronous reset between edges while running
      step(2);
      #2 reset = 1'b1;
      #1;
      check_out("async_reset", 24'h0, 4'h0, 1'b0, 1'b0);
      step(1);
      reset = 1'b0;
      step(1);
      start_pulse = 1'b1; step(1); start_pulse = 1'b0;
      step(8);
      check_out("start_in_idle", 24'h0, 4'h0, 1'b0, 1'b0);
      rom_content = 8'h31;
      load_pulse = 1'b1; step(1); load_pulse = 1'b0;
      check_out("reload", 24'h010000, 4'h3, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
